// File: rtl/ser_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// Optional parity stage is enabled by defining SER_TX_PARITY_EN.
package ser_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/ser_tx_baud_cnt.sv
// Modulo-BAUD_DIV bit-period counter; bit_tick marks the last clock of each serial bit.
module ser_tx_baud_cnt #(
    parameter int BAUD_DIV = 16
) (
    input  logic                        clk,
    input  logic                        CLRN,
    input  logic                        clr,
    input  logic                        en,
    output logic [$clog2(BAUD_DIV)-1:0] cnt,
    output logic                        bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);

    assign bit_tick = en && (cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ser_tx_shift.sv
// Parallel-in/serial-out frame transmitter: start, data LSB-first, [parity], stop.
// Define SER_TX_PARITY_EN to insert an even-parity bit between data and stop.
module ser_tx_shift
    import ser_tx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BAUD_DIV = 16
) (
    input  logic             clk,
    input  logic             CLRN,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic             TX,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(WIDTH + 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shnext;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    baud_cnt;
    logic             bit_tick;
`ifdef SER_TX_PARITY_EN
    logic             par;
`endif

    assign shnext = shreg >> 1;

    ser_tx_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .CLRN     (CLRN),
        .clr      (state == IDLE),
        .en       (state != IDLE),
        .cnt      (baud_cnt),
        .bit_tick (bit_tick)
    );

    // TX carries the level of the state being entered, so the line is glitch-free
    // and the first start-bit clock is the one right after acceptance.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            TX      <= IDLE_LVL;
            din_rdy <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    TX <= IDLE_LVL;
                    if (din_vld && din_rdy) begin
                        shreg   <= din;
                        bit_cnt <= '0;
`ifdef SER_TX_PARITY_EN
                        par     <= ^din;
`endif
                        state   <= START;
                        TX      <= START_LVL;
                        din_rdy <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state <= DATA;
                        TX    <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg   <= shnext;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(WIDTH - 1)) begin
`ifdef SER_TX_PARITY_EN
                            state <= PARITY;
                            TX    <= par;
`else
                            state <= STOP;
                            TX    <= STOP_LVL;
`endif
                        end else begin
                            TX <= shnext[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state <= STOP;
                        TX    <= STOP_LVL;
                    end
                end
                STOP: begin
                    // done is registered, so raise it one clock ahead of the final stop clock
                    if (baud_cnt == CW'(BAUD_DIV - 2)) begin
                        done <= 1'b1;
                    end
                    if (bit_tick) begin
                        state   <= IDLE;
                        TX      <= IDLE_LVL;
                        din_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    TX      <= IDLE_LVL;
                    din_rdy <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
